// File: rtl/mini_mips_cpu_pkg.sv
// Shared constants for the mini MIPS core: memory geometry, field slices, opcodes.
package mini_mips_cpu_pkg;

  localparam int ADDR_W     = 10;
  localparam int IMEM_DEPTH = 1 << ADDR_W;
  localparam int DMEM_DEPTH = 1 << ADDR_W;
  localparam int NUM_REGS   = 32;

  // Instruction field slices; rd and imm overlap on purpose.
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 25;
  localparam int RS_MSB  = 24;
  localparam int RS_LSB  = 20;
  localparam int RT_MSB  = 19;
  localparam int RT_LSB  = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 10;
  localparam int IMM_MSB = 14;
  localparam int IMM_LSB = 0;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_ADD  = 7'h00;
  localparam opcode_t OP_SUB  = 7'h01;
  localparam opcode_t OP_AND  = 7'h02;
  localparam opcode_t OP_OR   = 7'h03;
  localparam opcode_t OP_XOR  = 7'h04;
  localparam opcode_t OP_SLT  = 7'h05;
  localparam opcode_t OP_MUL  = 7'h06;
  localparam opcode_t OP_MFHI = 7'h07;
  localparam opcode_t OP_MFLO = 7'h08;
  localparam opcode_t OP_ADDI = 7'h20;
  localparam opcode_t OP_ANDI = 7'h21;
  localparam opcode_t OP_ORI  = 7'h23;
  localparam opcode_t OP_LUI  = 7'h29;
  localparam opcode_t OP_LW   = 7'h30;
  localparam opcode_t OP_SW   = 7'h31;
  localparam opcode_t OP_BEQ  = 7'h40;
  localparam opcode_t OP_BNE  = 7'h41;
  localparam opcode_t OP_J    = 7'h42;

  function automatic logic [31:0] sext_imm(input logic [14:0] imm);
    return {{17{imm[14]}}, imm};
  endfunction

endpackage

// File: rtl/mini_mips_alu.sv
// Combinational ALU; the top selects b (rt, simm, zimm or the lui constant).
module mini_mips_alu
  import mini_mips_cpu_pkg::*;
(
  input  opcode_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // Opcode -> operation; memory ops reuse add for the effective address.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
      OP_SUB:                        result = a - b;
      OP_AND, OP_ANDI:               result = a & b;
      OP_OR, OP_ORI:                 result = a | b;
      OP_XOR:                        result = a ^ b;
      OP_SLT:                        result = {31'b0, $signed(a) < $signed(b)};
      OP_LUI:                        result = b;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/mini_mips_cpu.sv
// Single-cycle word-addressed MIPS-style core with side-loaded IMEM.
module mini_mips_cpu
  import mini_mips_cpu_pkg::*;
(
  input  logic              gclk,
  input  logic              grst_n,
  input  logic [ADDR_W-1:0] write_instruction_address,
  input  logic [31:0]       write_instruction,
  input  logic              write_instruction_enable
);

  logic [31:0]       imem [IMEM_DEPTH];
  logic [31:0]       dmem [DMEM_DEPTH];
  logic [31:0]       gpr  [NUM_REGS];
  logic [31:0]       hi, lo;
  logic [ADDR_W-1:0] pc, pc_inc, pc_next, br_tgt;

  logic [31:0]        instr, rs_val, rt_val, simm, zimm, alu_b, alu_res, wb_data, dmem_rdata;
  opcode_t            op;
  logic [4:0]         rs, rt, rd, wb_addr;
  logic [14:0]        imm;
  logic               wb_en, hilo_we, dmem_we, exec_en;
  logic signed [63:0] product;

  assign instr   = imem[pc];
  assign op      = instr[OP_MSB:OP_LSB];
  assign rs      = instr[RS_MSB:RS_LSB];
  assign rt      = instr[RT_MSB:RT_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign imm     = instr[IMM_MSB:IMM_LSB];
  assign simm    = sext_imm(imm);
  assign zimm    = {17'b0, imm};
  assign rs_val  = (rs == '0) ? '0 : gpr[rs];
  assign rt_val  = (rt == '0) ? '0 : gpr[rt];
  assign pc_inc  = pc + ADDR_W'(1);
  assign br_tgt  = pc_inc + simm[ADDR_W-1:0];
  assign product = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign dmem_rdata = dmem[alu_res[ADDR_W-1:0]];
  assign exec_en = !write_instruction_enable;

  // Second ALU operand: immediate forms for I-type and memory ops, rt otherwise.
  always_comb begin
    alu_b = rt_val;
    case (op)
      OP_ADDI, OP_LW, OP_SW: alu_b = simm;
      OP_ANDI, OP_ORI:       alu_b = zimm;
      OP_LUI:                alu_b = {1'b0, imm, 16'b0};
      default:               alu_b = rt_val;
    endcase
  end

  mini_mips_alu u_alu (
    .op     (op),
    .a      (rs_val),
    .b      (alu_b),
    .result (alu_res)
  );

  // Decode: writeback select, HI/LO and DMEM enables, next PC.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rd;
    wb_data = alu_res;
    hilo_we = 1'b0;
    dmem_we = 1'b0;
    pc_next = pc_inc;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: wb_en = 1'b1;
      OP_MFHI: begin wb_en = 1'b1; wb_data = hi; end
      OP_MFLO: begin wb_en = 1'b1; wb_data = lo; end
      OP_MUL:  hilo_we = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin wb_en = 1'b1; wb_addr = rt; end
      OP_LW:   begin wb_en = 1'b1; wb_addr = rt; wb_data = dmem_rdata; end
      OP_SW:   dmem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_next = br_tgt;
      OP_BNE:  if (rs_val != rt_val) pc_next = br_tgt;
      OP_J:    pc_next = instr[ADDR_W-1:0];
      default: ;
    endcase
  end

  // Program load port; active even under reset so code can be staged early.
  always_ff @(posedge gclk) begin
    if (write_instruction_enable) imem[write_instruction_address] <= write_instruction;
  end

  // Data memory store; suppressed during reset and load stalls.
  always_ff @(posedge gclk) begin
    if (grst_n && exec_en && dmem_we) dmem[alu_res[ADDR_W-1:0]] <= rt_val;
  end

  // Architectural state: retire one instruction per edge unless stalled.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      pc <= '0;
      hi <= '0;
      lo <= '0;
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
    end else if (exec_en) begin
      pc <= pc_next;
      if (hilo_we) {hi, lo} <= product;
      if (wb_en && wb_addr != '0) gpr[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mini_mips_cpu.sv
// Scoreboard bench: stimulus runs an ISA-level model and queues the expected
// architectural state; monitors compare it against the core after each edge
// and immediately after an asynchronous reset assertion.
module tb_mini_mips_cpu;

  logic        gclk = 1'b0;
  logic        grst_n = 1'b0;
  logic        wen = 1'b0;
  logic [9:0]  waddr = '0;
  logic [31:0] wdata = '0;

  always #5 gclk = ~gclk;

  mini_mips_cpu dut (
    .gclk                      (gclk),
    .grst_n                    (grst_n),
    .write_instruction_address (waddr),
    .write_instruction         (wdata),
    .write_instruction_enable  (wen)
  );

  typedef struct packed {
    logic [9:0]        pc;
    logic [31:0]       hi;
    logic [31:0]       lo;
    logic [31:0][31:0] regs;
    logic              chk_im;
    logic [9:0]        im_addr;
    logic [31:0]       im_val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------- reference model (ISA level) ----------------
  logic [31:0] m_imem [1024];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_reg  [32];
  logic [31:0] m_hi, m_lo;
  int          m_pc;

  function automatic logic [31:0] r_ins(int op, int rd, int rs, int rt);
    logic [31:0] w;
    w = {7'(op), 5'(rs), 5'(rt), 5'(rd), 10'd0};
    return w;
  endfunction

  function automatic logic [31:0] i_ins(int op, int rt, int rs, int imm);
    logic [31:0] w;
    w = {7'(op), 5'(rs), 5'(rt), 15'(imm)};
    return w;
  endfunction

  task automatic setr(input int r, input logic [31:0] v);
    if (r != 0) m_reg[r] = v;
  endtask

  task automatic model_reset();
    m_pc = 0; m_hi = '0; m_lo = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, simm, zimm;
    int op, rs, rt, rd, npc, ea;
    longint p;
    ins  = m_imem[m_pc];
    op   = int'(ins[31:25]);
    rs   = int'(ins[24:20]);
    rt   = int'(ins[19:15]);
    rd   = int'(ins[14:10]);
    a    = m_reg[rs];
    b    = m_reg[rt];
    simm = {{17{ins[14]}}, ins[14:0]};
    zimm = {17'd0, ins[14:0]};
    ea   = int'((a + simm) & 32'h3FF);
    npc  = (m_pc + 1) % 1024;
    case (op)
      'h00: setr(rd, a + b);
      'h01: setr(rd, a - b);
      'h02: setr(rd, a & b);
      'h03: setr(rd, a | b);
      'h04: setr(rd, a ^ b);
      'h05: setr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
      'h06: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      'h07: setr(rd, m_hi);
      'h08: setr(rd, m_lo);
      'h20: setr(rt, a + simm);
      'h21: setr(rt, a & zimm);
      'h23: setr(rt, a | zimm);
      'h29: setr(rt, zimm << 16);
      'h30: setr(rt, m_dmem[ea]);
      'h31: m_dmem[ea] = b;
      'h40: if (a == b) npc = (m_pc + 1 + int'($signed(simm))) & 1023;
      'h41: if (a != b) npc = (m_pc + 1 + int'($signed(simm))) & 1023;
      'h42: npc = int'(ins[9:0]);
      default: ;
    endcase
    m_pc = npc;
  endtask

  function automatic exp_t snap();
    exp_t e;
    e = '0;
    e.pc = 10'(m_pc);
    e.hi = m_hi;
    e.lo = m_lo;
    for (int i = 0; i < 32; i++) e.regs[i] = m_reg[i];
    return e;
  endfunction

  // One clock edge with the inputs currently driven.
  task automatic tick();
    exp_t e;
    if (wen) m_imem[waddr] = wdata;
    if (!grst_n) model_reset();
    else if (!wen) model_step();
    e = snap();
    if (wen) begin
      e.chk_im  = 1'b1;
      e.im_addr = waddr;
      e.im_val  = wdata;
    end
    exp_q.push_back(e);
    @(negedge gclk);
  endtask

  task automatic load(input int addr, input logic [31:0] w);
    wen = 1'b1; waddr = 10'(addr); wdata = w;
    tick();
    wen = 1'b0;
  endtask

  task automatic async_reset();
    model_reset();
    exp_q.push_back(snap());
    grst_n = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check(input exp_t e);
    int bad;
    cmp("pc", {22'd0, dut.pc}, {22'd0, e.pc});
    cmp("hi", dut.hi, e.hi);
    cmp("lo", dut.lo, e.lo);
    bad = -1;
    for (int i = 31; i >= 0; i--) if (dut.gpr[i] !== e.regs[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL gpr[%0d]: got %h expected %h at %0t", bad, dut.gpr[bad], e.regs[bad], $time);
    end
    if (e.chk_im) cmp("imem", dut.imem[e.im_addr], e.im_val);
  endtask

  // Post-edge monitor.
  always @(posedge gclk) begin
    #1;
    if (exp_q.size() != 0) check(exp_q.pop_front());
  end

  // Reset must clear state without waiting for a clock edge.
  always @(negedge grst_n) begin
    #1;
    if (exp_q.size() != 0) check(exp_q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  int ops [19] = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08,
                   'h20, 'h21, 'h23, 'h29, 'h30, 'h31, 'h40, 'h41, 'h15, 'h7F};
  logic [31:0] prog_a[$];

  initial begin
    model_reset();
    @(negedge gclk);

    // Fill IMEM with NOPs (undefined opcode) under reset.
    for (int i = 0; i < 1024; i++) load(i, 32'hFE00_0000);

    prog_a.push_back(i_ins('h20, 1, 0, 8));        // addi $1,$0,8
    prog_a.push_back(i_ins('h20, 2, 0, 7));        // addi $2,$0,7
    prog_a.push_back(r_ins('h06, 0, 1, 2));        // mul $1,$2
    prog_a.push_back(r_ins('h08, 3, 0, 0));        // mflo $3
    prog_a.push_back(i_ins('h29, 10, 0, 'h418C));  // lui $10,0x418C
    prog_a.push_back(i_ins('h23, 10, 10, 0));      // ori $10,$10,0
    prog_a.push_back(i_ins('h20, 1, 0, -1));       // addi $1,$0,-1
    prog_a.push_back(r_ins('h06, 0, 1, 1));        // mul $1,$1
    prog_a.push_back(i_ins('h20, 1, 0, 5));        // addi $1,$0,5
    prog_a.push_back(i_ins('h31, 1, 0, 3));        // sw $1,3($0)
    prog_a.push_back(i_ins('h30, 4, 0, 3));        // lw $4,3($0)
    prog_a.push_back(i_ins('h20, 0, 0, 9));        // addi $0,$0,9
    prog_a.push_back(r_ins('h7E, 5, 1, 1));        // unknown opcode
    prog_a.push_back(r_ins('h01, 8, 0, 1));        // sub $8,$0,$1
    prog_a.push_back(r_ins('h05, 9, 8, 1));        // slt $9,$8,$1
    prog_a.push_back(i_ins('h40, 0, 0, 2));        // beq $0,$0,+2
    prog_a.push_back(i_ins('h20, 5, 0, 1));        // skipped
    prog_a.push_back(i_ins('h20, 6, 0, 1));        // skipped
    prog_a.push_back(r_ins('h07, 11, 0, 0));       // mfhi $11
    prog_a.push_back(i_ins('h42, 0, 0, 0));        // j 0
    foreach (prog_a[i]) load(i, prog_a[i]);

    grst_n = 1'b1;
    repeat (30) tick();

    // Load stall mid-program.
    for (int i = 0; i < 3; i++) load(100 + i, $urandom);
    repeat (10) tick();

    // Asynchronous reset mid-run, then re-execute from 0.
    async_reset();
    repeat (2) tick();
    grst_n = 1'b1;
    repeat (25) tick();

    // Random program, loaded under reset.
    async_reset();
    for (int k = 0; k < 8; k++) load(k, i_ins('h31, 0, 0, k));  // sw $0,k($0)
    for (int i = 8; i < 199; i++) begin
      int op, rd, rs, rt, imm;
      op  = ops[$urandom_range(18)];
      rd  = $urandom_range(7);
      rs  = $urandom_range(7);
      rt  = $urandom_range(7);
      imm = $urandom_range(32767);
      if (op == 'h30 || op == 'h31) begin rs = 0; imm = $urandom_range(7); end
      if (op == 'h40 || op == 'h41) imm = $urandom_range(3);
      load(i, (op < 'h20) ? r_ins(op, rd, rs, rt) : i_ins(op, rt, rs, imm));
    end
    for (int i = 199; i < 204; i++) load(i, i_ins('h42, 0, 0, 0));
    grst_n = 1'b1;
    repeat (800) begin
      if ($urandom_range(15) == 0) begin
        wen = 1'b1; waddr = 10'(900 + $urandom_range(99)); wdata = $urandom;
      end
      tick();
      wen = 1'b0;
    end

    #10;
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
